// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  // Default operand width (MIPS general-purpose register width).
  localparam int DIV_WIDTH = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// result = {remainder, quotient}; the remainder takes the sign of the
// dividend and the quotient truncates toward zero.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic               cancel,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e state_reg, state_next;

  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH-1:0]   rem_reg;       // partial remainder
  logic [WIDTH-1:0]   dvd_reg;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   divisor_reg;   // |b| (or raw b for unsigned)
  logic               q_neg_reg;
  logic               r_neg_reg;
  logic [2*WIDTH-1:0] result_reg;

  logic               last_iter;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   dvd_next;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, try to subtract.
  always_comb begin
    rem_ext  = {rem_reg, dvd_reg[WIDTH-1]};
    trial    = rem_ext - {1'b0, divisor_reg};
    rem_next = trial[WIDTH] ? rem_ext[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_next = {dvd_reg[WIDTH-2:0], ~trial[WIDTH]};
    quot_fix = q_neg_reg ? -dvd_next : dvd_next;
    rem_fix  = r_neg_reg ? -rem_next : rem_next;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; cancel overrides everything.
  always_comb begin
    state_next = state_reg;
    if (cancel) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = (b == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (last_iter) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    busy         = (state_reg != IDLE);
    result_valid = (state_reg == DONE);
  end

  assign result = result_reg;

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= '0;
      rem_reg     <= '0;
      dvd_reg     <= '0;
      divisor_reg <= '0;
      q_neg_reg   <= 1'b0;
      r_neg_reg   <= 1'b0;
      result_reg  <= '0;
    end else if (!cancel) begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            dvd_reg     <= (sign && a[WIDTH-1]) ? -a : a;
            divisor_reg <= (sign && b[WIDTH-1]) ? -b : b;
            q_neg_reg   <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_reg   <= sign & a[WIDTH-1];
            rem_reg     <= '0;
            count_reg   <= '0;
            // Divide by zero: all-ones quotient, raw dividend as remainder.
            if (b == '0) begin
              result_reg <= {a, {WIDTH{1'b1}}};
            end
          end
        end
        BUSY: begin
          rem_reg   <= rem_next;
          dvd_reg   <= dvd_next;
          count_reg <= count_reg + 1'b1;
          if (last_iter) begin
            result_reg <= {rem_fix, quot_fix};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
